// File: rtl/pipeline_control_pkg.sv
// Shared constants for the pipeline stall controller: stall bit indices,
// stall levels, reset level and the EX/MEM FSM state encodings.
package pipeline_control_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam int STALL_WIDTH = STALL_WB + 1;

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;

    localparam logic RESET_ACTIVE_LEVEL = 1'b0;

    localparam logic [1:0] EX_IDLE = 2'd0;
    localparam logic [1:0] EX_BUSY = 2'd1;
    localparam logic [1:0] EX_DONE = 2'd2;

    localparam logic MEM_IDLE = 1'b0;
    localparam logic MEM_WAIT = 1'b1;

    // Contiguous stall run from the PC up to and including last_stage, so a
    // bubble always appears directly below the stalling stage.
    function automatic logic [STALL_WIDTH-1:0] stall_through(input int last_stage);
        logic [STALL_WIDTH-1:0] vec;
        vec = {STALL_WIDTH{STALL_DISABLE}};
        for (int i = 0; i < STALL_WIDTH; i++) begin
            if (i <= last_stage) begin
                vec[i] = STALL_ENABLE;
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/pipeline_control_ex_multicycle_counter.sv
// Fixed-latency multi-cycle EX sequencer: IDLE/BUSY/DONE FSM with a
// load/decrement counter. Exposes its state for debug.
module ex_multicycle_counter
    import pipeline_control_pkg::*;
#(
    parameter int LATENCY_WIDTH = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [LATENCY_WIDTH-1:0] latency_i,
    input  logic                     mem_stall_i,
    output logic                     ex_stall_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [1:0]               state_o
);

    logic [1:0]               state_q, state_d;
    logic [LATENCY_WIDTH-1:0] count_q, count_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ex_stall_o = STALL_DISABLE;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            EX_IDLE: begin
                if (start_i) begin
                    ex_stall_o = STALL_ENABLE;
                    // A zero latency behaves as one cycle.
                    count_d = (latency_i == '0) ? '0 : latency_i - LATENCY_WIDTH'(1);
                    state_d = (latency_i <= LATENCY_WIDTH'(1)) ? EX_DONE : EX_BUSY;
                end
            end
            EX_BUSY: begin
                ex_stall_o = STALL_ENABLE;
                busy_o     = 1'b1;
                count_d    = (count_q == '0) ? '0 : count_q - LATENCY_WIDTH'(1);
                if (count_q <= LATENCY_WIDTH'(1)) begin
                    state_d = EX_DONE;
                end
            end
            EX_DONE: begin
                done_o = 1'b1;
                // Held while MEM stalls so a still-asserted start cannot relaunch.
                if (!mem_stall_i) begin
                    state_d = EX_IDLE;
                end
            end
            default: begin
                state_d = EX_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EX_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/pipeline_control.sv
// Central stall controller: MEM bus handshake FSM, stall priority encoder and
// optional stall watchdog (compiled in with STALL_WATCHDOG_EN).
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int LATENCY_WIDTH  = 6,
    parameter int WATCHDOG_LIMIT = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     if_stall_request,
    input  logic                     id_stall_request,
    input  logic                     ex_multicycle_start,
    input  logic [LATENCY_WIDTH-1:0] ex_multicycle_latency,
    input  logic                     mem_request,
    input  logic                     mem_ack,
    output logic [5:0]               stall,
    output logic                     ex_busy,
    output logic                     ex_multicycle_done,
    output logic                     mem_bus_valid,
    output logic                     stall_timeout
);

    logic                   out_en;
    logic                   mem_state_q, mem_state_d;
    logic                   mem_valid_raw;
    logic                   mem_stall_raw;
    logic                   ex_stall_raw;
    logic                   ex_busy_raw;
    logic                   ex_done_raw;
    logic [1:0]             ex_state;
    logic [STALL_WIDTH-1:0] stall_vec;

    // Outputs are forced low while reset is held, even with requests present.
    assign out_en = (reset != RESET_ACTIVE_LEVEL);

    assign mem_valid_raw = mem_request | (mem_state_q == MEM_WAIT);
    assign mem_stall_raw = mem_valid_raw & ~mem_ack;

    always_comb begin
        mem_state_d = mem_state_q;
        case (mem_state_q)
            MEM_IDLE: if (mem_request && !mem_ack) mem_state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ack)                 mem_state_d = MEM_IDLE;
            default:                               mem_state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_state_q <= MEM_IDLE;
        end else begin
            mem_state_q <= mem_state_d;
        end
    end

    ex_multicycle_counter #(
        .LATENCY_WIDTH(LATENCY_WIDTH)
    ) u_ex_counter (
        .clk_i      (clock),
        .rst_ni     (reset),
        .start_i    (ex_multicycle_start),
        .latency_i  (ex_multicycle_latency),
        .mem_stall_i(stall_vec[STALL_MEM]),
        .ex_stall_o (ex_stall_raw),
        .busy_o     (ex_busy_raw),
        .done_o     (ex_done_raw),
        .state_o    (ex_state)
    );

    always_comb begin
        stall_vec = {STALL_WIDTH{STALL_DISABLE}};
        if (mem_stall_raw) begin
            stall_vec = stall_through(STALL_MEM);
        end else if (ex_stall_raw) begin
            stall_vec = stall_through(STALL_EX);
        end else if (id_stall_request) begin
            stall_vec = stall_through(STALL_ID);
        end else if (if_stall_request) begin
            stall_vec = stall_through(STALL_IF);
        end
    end

    assign stall              = out_en ? stall_vec : '0;
    assign ex_busy            = out_en & ex_busy_raw & (ex_state == EX_BUSY);
    assign ex_multicycle_done = out_en & ex_done_raw & (ex_state == EX_DONE);
    assign mem_bus_valid      = out_en & mem_valid_raw;

`ifdef STALL_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_LIMIT + 1);

    logic [WD_W-1:0] wd_count_q, wd_count_d;
    logic            timeout_q, timeout_d;

    // Counts consecutive stalled cycles, saturating at the limit.
    always_comb begin
        wd_count_d = '0;
        if (|stall_vec) begin
            wd_count_d = (wd_count_q == WD_W'(WATCHDOG_LIMIT)) ? wd_count_q
                                                               : wd_count_q + 1'b1;
        end
        timeout_d = timeout_q | (wd_count_d == WD_W'(WATCHDOG_LIMIT));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_count_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wd_count_q <= wd_count_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stall_timeout = out_en & timeout_q;
`else
    // Parameter still referenced so both builds elaborate the same interface.
    assign stall_timeout = STALL_DISABLE & (WATCHDOG_LIMIT != 0);
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipeline_control;

    localparam int LW       = 6;
    localparam int WD_LIMIT = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_req, id_req, start, mem_req, mem_ack;
    logic [LW-1:0] lat;
    logic [5:0]    stall;
    logic          ex_busy, ex_done, mem_valid, timeout;

    int checks = 0;
    int errors = 0;

    // Model: remaining BUSY cycles, pending done, MEM waiting, watchdog run.
    int   m_ex_rem;
    bit   m_done_pend;
    bit   m_mem_wait;
    int   m_consec;
    bit   m_timeout;
    logic [5:0] exp_stall;
    logic exp_busy, exp_done, exp_valid, exp_timeout;
    bit   exp_mem_stall;

    pipeline_control #(
        .LATENCY_WIDTH (LW),
        .WATCHDOG_LIMIT(WD_LIMIT)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .if_stall_request     (if_req),
        .id_stall_request     (id_req),
        .ex_multicycle_start  (start),
        .ex_multicycle_latency(lat),
        .mem_request          (mem_req),
        .mem_ack              (mem_ack),
        .stall                (stall),
        .ex_busy              (ex_busy),
        .ex_multicycle_done   (ex_done),
        .mem_bus_valid        (mem_valid),
        .stall_timeout        (timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit=%0d", 200000);
        $fatal(1, "bench timeout");
    end

    function automatic void model_reset();
        m_ex_rem = 0; m_done_pend = 0; m_mem_wait = 0; m_consec = 0; m_timeout = 0;
    endfunction

    function automatic void model_eval();
        bit ex_stall;
        exp_valid     = mem_req || m_mem_wait;
        exp_mem_stall = exp_valid && !mem_ack;
        ex_stall = 0; exp_busy = 0; exp_done = 0;
        if (m_done_pend) exp_done = 1;
        else if (m_ex_rem > 0) begin exp_busy = 1; ex_stall = 1; end
        else if (start) ex_stall = 1;
        if (exp_mem_stall)  exp_stall = 6'b011111;
        else if (ex_stall)  exp_stall = 6'b001111;
        else if (id_req)    exp_stall = 6'b000111;
        else if (if_req)    exp_stall = 6'b000011;
        else                exp_stall = 6'b000000;
`ifdef STALL_WATCHDOG_EN
        exp_timeout = m_timeout;
`else
        exp_timeout = 1'b0;
`endif
    endfunction

    function automatic void model_update();
        model_eval();
        m_mem_wait = exp_valid && !mem_ack;
        if (m_done_pend) begin
            if (!exp_mem_stall) m_done_pend = 0;
        end else if (m_ex_rem > 0) begin
            m_ex_rem--;
            if (m_ex_rem == 0) m_done_pend = 1;
        end else if (start) begin
            m_ex_rem = ((lat == 0) ? 1 : int'(lat)) - 1;
            if (m_ex_rem == 0) m_done_pend = 1;
        end
        if (exp_stall != 0) m_consec++; else m_consec = 0;
        if (m_consec >= WD_LIMIT) m_timeout = 1;
    endfunction

    task automatic drive(input logic i_if, input logic i_id, input logic i_start,
                         input int n, input logic i_req, input logic i_ack);
        if_req = i_if; id_req = i_id; start = i_start; lat = LW'(n);
        mem_req = i_req; mem_ack = i_ack;
    endtask

    task automatic settle();
        @(negedge clock);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        advance();
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 5, 1, 0);
        #3;
        checks++;
        if ({stall, ex_busy, ex_done, mem_valid, timeout} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b busy=%b done=%b valid=%b timeout=%b, expected all 0",
                     stall, ex_busy, ex_done, mem_valid, timeout);
        end
        do_reset();
        settle();
        checks++;
        if (stall !== 6'b000000) begin
            errors++; $display("FAIL reset_release_stall: got %b expected 000000", stall);
        end
        advance();
    endtask

    task automatic test_id_stall();
        drive(0, 1, 0, 0, 0, 0);
        settle();
        checks++;
        if (stall !== 6'b000111) begin
            errors++; $display("FAIL id_stall: got %b expected 000111", stall);
        end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (stall !== 6'b000000) begin
            errors++; $display("FAIL id_stall_release: got %b expected 000000", stall);
        end
        advance();
        drive(1, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (stall !== 6'b000011) begin
            errors++; $display("FAIL if_stall: got %b expected 000011", stall);
        end
        advance();
    endtask

    task automatic test_multicycle();
        drive(0, 1, 1, 4, 0, 0);
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (stall !== 6'b001111 || ex_busy !== (c > 0) || ex_done !== 1'b0) begin
                errors++;
                $display("FAIL mc_busy[%0d]: got stall=%b busy=%b done=%b expected 001111/%0d/0",
                         c, stall, ex_busy, ex_done, (c > 0));
            end
            advance();
        end
        drive(0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (ex_done !== 1'b1 || stall !== 6'b000000 || ex_busy !== 1'b0) begin
            errors++;
            $display("FAIL mc_done: got done=%b stall=%b busy=%b expected 1/000000/0", ex_done, stall, ex_busy);
        end
        advance();
        settle();
        checks++;
        if (ex_done !== 1'b0) begin
            errors++; $display("FAIL mc_done_clear: got %b expected 0", ex_done);
        end
        advance();
    endtask

    task automatic test_mem();
        drive(0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (stall !== 6'b011111 || mem_valid !== 1'b1) begin
                errors++; $display("FAIL mem_wait[%0d]: got stall=%b valid=%b expected 011111/1", c, stall, mem_valid);
            end
            advance();
        end
        mem_ack = 1'b1;
        settle();
        checks++;
        if (stall !== 6'b000000 || mem_valid !== 1'b1) begin
            errors++; $display("FAIL mem_ack_cycle: got stall=%b valid=%b expected 000000/1", stall, mem_valid);
        end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (mem_valid !== 1'b0) begin
            errors++; $display("FAIL mem_idle_valid: got %b expected 0", mem_valid);
        end
        advance();
        drive(0, 0, 0, 0, 1, 1);
        settle();
        checks++;
        if (stall !== 6'b000000 || mem_valid !== 1'b1) begin
            errors++; $display("FAIL mem_zero_wait: got stall=%b valid=%b expected 000000/1", stall, mem_valid);
        end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        advance();
    endtask

    task automatic test_ex_mem_overlap();
        drive(0, 0, 1, 2, 1, 0);
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (stall !== 6'b011111 || ex_busy !== (c == 1) || ex_done !== (c >= 2)) begin
                errors++;
                $display("FAIL overlap[%0d]: got stall=%b busy=%b done=%b expected 011111/%0d/%0d",
                         c, stall, ex_busy, ex_done, (c == 1), (c >= 2));
            end
            advance();
        end
        mem_ack = 1'b1;
        settle();
        checks++;
        if (stall !== 6'b000000 || ex_done !== 1'b1) begin
            errors++; $display("FAIL overlap_release: got stall=%b done=%b expected 000000/1", stall, ex_done);
        end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (stall !== 6'b000000 || ex_done !== 1'b0 || ex_busy !== 1'b0) begin
            errors++; $display("FAIL overlap_after: got stall=%b done=%b busy=%b expected 000000/0/0", stall, ex_done, ex_busy);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 1, 3, 0, 0);
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (c == 3) begin
                if (stall !== 6'b000000 || ex_done !== 1'b1) begin
                    errors++; $display("FAIL b2b_done: got stall=%b done=%b expected 000000/1", stall, ex_done);
                end
            end else if (stall !== 6'b001111 || ex_busy !== (c == 1 || c == 2) || ex_done !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d]: got stall=%b busy=%b done=%b expected 001111/%0d/0",
                         c, stall, ex_busy, ex_done, (c == 1 || c == 2));
            end
            advance();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) advance();
    endtask

    task automatic test_reset_mid_op();
        drive(0, 0, 1, 10, 0, 0);
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (stall !== 6'b001111) begin
                errors++; $display("FAIL rst_pre[%0d]: got %b expected 001111", c, stall);
            end
            advance();
        end
        drive(1, 1, 1, 10, 1, 0);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({stall, ex_busy, ex_done, mem_valid, timeout} !== 10'b0) begin
            errors++;
            $display("FAIL rst_async: got stall=%b busy=%b done=%b valid=%b expected all 0",
                     stall, ex_busy, ex_done, mem_valid);
        end
        do_reset();
        drive(0, 0, 1, 1, 0, 0);
        settle();
        checks++;
        if (stall !== 6'b001111 || ex_busy !== 1'b0) begin
            errors++; $display("FAIL rst_fresh_start: got stall=%b busy=%b expected 001111/0", stall, ex_busy);
        end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (ex_done !== 1'b1 || stall !== 6'b000000) begin
            errors++; $display("FAIL rst_fresh_done: got done=%b stall=%b expected 1/000000", ex_done, stall);
        end
        advance();
        advance();
    endtask

    task automatic test_watchdog();
        do_reset();
`ifdef STALL_WATCHDOG_EN
        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < WD_LIMIT; c++) begin
            settle();
            checks++;
            if (timeout !== 1'b0) begin
                errors++; $display("FAIL wd_early[%0d]: got %b expected 0", c, timeout);
            end
            advance();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (timeout !== 1'b1) begin
                errors++; $display("FAIL wd_sticky[%0d]: got %b expected 1", c, timeout);
            end
            advance();
        end
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(1, 0, 0, 0, 0, 0);
            for (int c = 0; c < WD_LIMIT - 1; c++) advance();
            drive(0, 0, 0, 0, 0, 0);
            advance();
        end
        settle();
        checks++;
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL wd_short_runs: got %b expected 0", timeout);
        end
        advance();
`else
        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3 * WD_LIMIT; c++) advance();
        settle();
        checks++;
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL wd_disabled: got %b expected 0", timeout);
        end
        advance();
`endif
        do_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7),
                  m_mem_wait ? 1'b1 : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 2) == 0);
            settle();
            checks++;
            if (stall !== exp_stall) begin
                errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", c, stall, exp_stall);
            end
            checks++;
            if ({ex_busy, ex_done} !== {exp_busy, exp_done}) begin
                errors++; $display("FAIL rnd_ex[%0d]: got busy=%b done=%b expected %b/%b",
                                   c, ex_busy, ex_done, exp_busy, exp_done);
            end
            checks++;
            if ({mem_valid, timeout} !== {exp_valid, exp_timeout}) begin
                errors++; $display("FAIL rnd_mem[%0d]: got valid=%b timeout=%b expected %b/%b",
                                   c, mem_valid, timeout, exp_valid, exp_timeout);
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        test_reset();
        test_id_stall();
        test_multicycle();
        test_mem();
        test_ex_mem_overlap();
        test_back_to_back();
        test_reset_mid_op();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
